// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
// Holds the FSM states, op encodings, iteration count and a magnitude helper.
package muldiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic        OP_MULT = 1'b0;
  localparam logic        OP_DIV  = 1'b1;
  localparam int unsigned ITER    = 32;

  // Two's-complement magnitude; -2^31 maps to 0x80000000 as an unsigned value
  function automatic logic [31:0] abs32(input logic [31:0] v);
    logic [31:0] r;
    if (v[31]) begin
      r = 32'd0 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the unsigned core: shift-add for MULT,
// restoring shift-subtract for DIV, over a 64-bit {hi, lo} accumulator.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic        i_op,
  input  logic [31:0] i_b,
  input  logic [63:0] i_acc,
  output logic [63:0] o_acc
);

  logic [32:0] w_sum;
  logic [32:0] w_diff;

  assign w_sum  = {1'b0, i_acc[63:32]} + {1'b0, i_b};
  assign w_diff = i_acc[63:31] - {1'b0, i_b};

  // Next accumulator value for the selected operation
  always_comb begin
    o_acc = i_acc;
    case (i_op)
      OP_MULT: begin
        if (i_acc[0]) begin
          o_acc = {w_sum, i_acc[31:1]};
        end else begin
          o_acc = {1'b0, i_acc[63:1]};
        end
      end
      OP_DIV: begin
        // Keep the trial difference only when it did not go negative
        if (!w_diff[32]) begin
          o_acc = {w_diff[31:0], i_acc[30:0], 1'b1};
        end else begin
          o_acc = {i_acc[62:0], 1'b0};
        end
      end
      default: begin
        o_acc = i_acc;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the 32-iteration signed multiply/divide unit: latches operands,
// runs the step datapath, applies sign fix-up and publishes HI/LO.
module muldiv_ctrl #(
  parameter int unsigned ITER = muldiv_pkg::ITER
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic        Div0,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  import muldiv_pkg::*;

  state_t      r_state;
  logic        r_op;
  logic        r_sign_a;
  logic        r_sign_b;
  logic [31:0] r_b_mag;
  logic [63:0] r_acc;
  logic [5:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_div0;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [63:0] w_acc_next;
  logic [63:0] w_prod;
  logic [31:0] w_fix_hi;
  logic [31:0] w_fix_lo;

  muldiv_step u_step (
    .i_op  (r_op),
    .i_b   (r_b_mag),
    .i_acc (r_acc),
    .o_acc (w_acc_next)
  );

  // Sign fix-up of the unsigned result into the final HI/LO values
  always_comb begin
    w_prod   = 64'd0;
    w_fix_hi = 32'd0;
    w_fix_lo = 32'd0;
    if (r_op == OP_MULT) begin
      if (r_sign_a ^ r_sign_b) begin
        w_prod = 64'd0 - r_acc;
      end else begin
        w_prod = r_acc;
      end
      w_fix_hi = w_prod[63:32];
      w_fix_lo = w_prod[31:0];
    end else begin
      if (r_sign_a ^ r_sign_b) begin
        w_fix_lo = 32'd0 - r_acc[31:0];
      end else begin
        w_fix_lo = r_acc[31:0];
      end
      // Remainder takes the sign of the dividend
      if (r_sign_a) begin
        w_fix_hi = 32'd0 - r_acc[63:32];
      end else begin
        w_fix_hi = r_acc[63:32];
      end
    end
  end

  // Control FSM with registered status outputs and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= OP_MULT;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_b_mag  <= 32'd0;
      r_acc    <= 64'd0;
      r_cnt    <= 6'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_div0   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_div0 <= 1'b0;
          if (start) begin
            r_op     <= op;
            r_sign_a <= A[31];
            r_sign_b <= B[31];
            r_b_mag  <= abs32(B);
            r_acc    <= {32'd0, abs32(A)};
            r_cnt    <= 6'd0;
            r_busy   <= 1'b1;
            // Divide by zero skips the datapath and leaves HI/LO untouched
            if ((op == OP_DIV) && (B == 32'd0)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_div0  <= 1'b1;
            end else begin
              r_state <= S_CALC;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'(ITER - 1)) begin
            r_state <= S_FIX;
          end else begin
            r_state <= S_CALC;
          end
        end
        S_FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_div0  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_div0  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign Div0 = r_div0;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table plus hand-written
// sequences for ignored restarts, mid-operation reset and reset/start priority.
module tb_muldiv_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic        Div0;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] cur_hi = 32'd0;
  logic [31:0] cur_lo = 32'd0;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_div0;
    int          exp_lat;
  } vec_t;

  vec_t vecs[13];

  muldiv_ctrl dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Div0  (Div0),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input int id, input logic op_i, input logic [31:0] a_i,
                        input logic [31:0] b_i, input logic [31:0] eh,
                        input logic [31:0] el, input logic ed, input int elat);
    int k;
    @(negedge clock);
    op = op_i; A = a_i; B = b_i; start = 1'b1;
    @(negedge clock);
    // Scramble inputs while busy; the result must not depend on them
    start = 1'b0; op = ~op_i; A = ~a_i; B = b_i ^ 32'h5A5A_0F0F;
    k = 1;
    chk($sformatf("v%0d_busy", id), {31'd0, busy}, 32'd1);
    if (elat > 1) begin
      chk($sformatf("v%0d_hold_hi", id), hi, cur_hi);
      chk($sformatf("v%0d_hold_lo", id), lo, cur_lo);
    end
    while (done !== 1'b1 && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk($sformatf("v%0d_latency", id), k, elat);
    chk($sformatf("v%0d_hi", id), hi, eh);
    chk($sformatf("v%0d_lo", id), lo, el);
    chk($sformatf("v%0d_div0", id), {31'd0, Div0}, {31'd0, ed});
    @(negedge clock);
    chk($sformatf("v%0d_done_once", id), {31'd0, done}, 32'd0);
    chk($sformatf("v%0d_idle", id), {31'd0, busy}, 32'd0);
    cur_hi = eh;
    cur_lo = el;
  endtask

  initial begin
    int dones;
    int lat;
    logic [31:0] got_hi;
    logic [31:0] got_lo;

    //            op    A              B              hi             lo             div0  lat
    vecs[0]  = '{1'b1, 32'd7,         32'd2,         32'd1,         32'd3,         1'b0, 34};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
    vecs[2]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0, 34};
    vecs[3]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0, 34};
    vecs[4]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 34};
    vecs[5]  = '{1'b1, 32'd5,         32'd0,         32'd0,         32'h8000_0000, 1'b1, 1};
    vecs[6]  = '{1'b0, 32'd3,         32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0, 34};
    vecs[7]  = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 34};
    vecs[8]  = '{1'b0, 32'h1234_5678, 32'h10,        32'd1,         32'h2345_6780, 1'b0, 34};
    vecs[9]  = '{1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 34};
    vecs[10] = '{1'b0, 32'd0,         32'd5,         32'd0,         32'd0,         1'b0, 34};
    vecs[11] = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14,        1'b0, 34};
    vecs[12] = '{1'b1, 32'd3,         32'd5,         32'd3,         32'd0,         1'b0, 34};

    reset = 1'b1; start = 1'b0; op = 1'b0; A = 32'd0; B = 32'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_div0", {31'd0, Div0}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    for (int i = 0; i < 13; i++) begin
      run_op(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi,
             vecs[i].exp_lo, vecs[i].exp_div0, vecs[i].exp_lat);
    end

    // Second start with different operands mid-operation must be ignored
    @(negedge clock);
    op = 1'b1; A = 32'd100; B = 32'd7; start = 1'b1;
    dones = 0; lat = 0; got_hi = 32'd0; got_lo = 32'd0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        dones++;
        lat = k;
        got_hi = hi;
        got_lo = lo;
      end
      if (k == 10) begin
        start = 1'b1; op = 1'b0; A = 32'd55; B = 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    chk("restart_dones", dones, 32'd1);
    chk("restart_lat", lat, 32'd34);
    chk("restart_hi", got_hi, 32'd2);
    chk("restart_lo", got_lo, 32'd14);

    // Reset mid-CALC aborts without done and clears HI/LO
    @(negedge clock);
    op = 1'b0; A = 32'd3; B = 32'd4; start = 1'b1;
    dones = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (done === 1'b1) dones++;
      reset = (k == 15);
    end
    chk("abort_dones", dones, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    run_op(20, 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 34);

    // Reset wins over start on the same edge
    @(negedge clock);
    reset = 1'b1; start = 1'b1; op = 1'b0; A = 32'd6; B = 32'd7;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    chk("prio_busy", {31'd0, busy}, 32'd0);
    chk("prio_hi", hi, 32'd0);
    chk("prio_lo", lo, 32'd0);
    dones = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (done === 1'b1) dones++;
    end
    chk("prio_dones", dones, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
